// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
//   div_state_t     : FSM state encoding used by seq_divider
//   DIV0_QUOT_FILL  : fill bit for the quotient returned on divide-by-zero
//                     (replicated to WIDTH bits, giving an all-ones quotient)
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam logic DIV0_QUOT_FILL = 1'b1;

endpackage

// File: rtl/seq_divider_step.sv
// One restoring-division iteration (purely combinational).
// Ports:
//   rem      in  WIDTH+1  partial remainder from the previous iteration
//   dvd_msb  in  1        next dividend bit to bring down
//   divisor  in  WIDTH    divisor (non-zero while iterating)
//   rem_next out WIDTH+1  partial remainder after this iteration
//   qbit     out 1        quotient bit produced by this iteration
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             qbit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // A restored remainder is always below the divisor, so its top bit is
  // zero on entry and can be dropped by the shift.
  logic rem_top_unused;
  assign rem_top_unused = rem[WIDTH];

  assign shifted  = {rem[WIDTH-1:0], dvd_msb};
  assign diff     = shifted - {1'b0, divisor};
  assign qbit     = (shifted >= {1'b0, divisor});
  assign rem_next = qbit ? diff : shifted;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid, in_ready            operand handshake (in_ready only in IDLE)
//   dividend, divisor             operands, sampled on the operand handshake
//   out_valid, out_ready          result handshake
//   quotient, remainder           result; held until the result handshake
//   div_by_zero                   result came from a zero divisor
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for an operand pair, in_ready=1
// CALC  | WIDTH shift-and-subtract steps, count runs WIDTH-1 down to 0
// DONE  | result presented, out_valid=1, waiting for out_ready
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_t       state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH:0]   rem_r;
  logic [WIDTH:0]   rem_next;
  logic             qbit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_r),
    .dvd_msb  (dvd[WIDTH-1]),
    .divisor  (dsr),
    .rem_next (rem_next),
    .qbit     (qbit)
  );

  // The dividend register doubles as the quotient accumulator: each step
  // shifts one dividend bit out of the top and one quotient bit into the
  // bottom, so after WIDTH steps it holds the full quotient.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      count       <= '0;
      dvd         <= '0;
      dsr         <= '0;
      rem_r       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            if (divisor == '0) begin
              quotient    <= {WIDTH{DIV0_QUOT_FILL}};
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
              state       <= DONE;
            end else begin
              dvd   <= dividend;
              dsr   <= divisor;
              rem_r <= '0;
              count <= CNT_LAST;
              state <= CALC;
            end
          end
        end

        CALC: begin
          rem_r <= rem_next;
          dvd   <= {dvd[WIDTH-2:0], qbit};
          count <= count - CNT_W'(1);
          if (count == '0) begin
            quotient    <= {dvd[WIDTH-2:0], qbit};
            remainder   <= rem_next[WIDTH-1:0];
            div_by_zero <= 1'b0;
            out_valid   <= 1'b1;
            state       <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: accepted operand pairs push their
// expected result, a monitor pops and compares on every result transfer.
module tb_seq_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_in     = 0;
  int n_out    = 0;
  bit rand_mode = 1'b0;

  logic [2*W:0] exp_q[$];
  logic [2*W:0] exp_e;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Input side of the scoreboard: inputs are stable between posedge+1 and
  // the next posedge, so a handshake seen here is the one about to happen.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      n_in++;
      if (divisor == '0)
        exp_q.push_back({1'b1, {W{1'b1}}, dividend});
      else
        exp_q.push_back({1'b0, W'(dividend / divisor), W'(dividend % divisor)});
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=q%0d/r%0d required=no_result", quotient, remainder);
      end else begin
        exp_e = exp_q.pop_front();
        chk("quotient",    32'(quotient),    32'(exp_e[2*W-1:W]));
        chk("remainder",   32'(remainder),   32'(exp_e[W-1:0]));
        chk("div_by_zero", 32'(div_by_zero), 32'(exp_e[2*W]));
      end
    end
  end

  always @(posedge clk) begin
    if (rand_mode) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Present one operand pair as soon as the divider is ready; returns the
  // cycle in which the pair was presented (the transfer cycle).
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, output int t0);
    int guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("in_ready_before_send", 32'(in_ready), 32'd1);
    t0       = cyc;
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic op_with_latency(input logic [W-1:0] a, input logic [W-1:0] b, input int lat);
    int t0;
    int guard = 0;
    send(a, b, t0);
    while (!out_valid && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("out_valid_seen", 32'(out_valid), 32'd1);
    chk("latency", 32'(cyc - t0), 32'(lat));
    @(posedge clk); #1;
  endtask

  initial begin
    int t0;
    int t1;
    int guard;
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit accepted;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready",    32'(in_ready),    32'd1);
    chk("reset_out_valid",   32'(out_valid),   32'd0);
    chk("reset_quotient",    32'(quotient),    32'd0);
    chk("reset_remainder",   32'(remainder),   32'd0);
    chk("reset_div_by_zero", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    out_ready = 1'b1;
    op_with_latency(8'd100, 8'd7, 9);
    op_with_latency(8'd255, 8'd1, 9);
    op_with_latency(8'd0,   8'd5, 9);
    op_with_latency(8'd42,  8'd0, 1);
    op_with_latency(8'd3,   8'd200, 9);

    // Result held while the consumer stalls.
    out_ready = 1'b0;
    send(8'd200, 8'd3, t0);
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    for (int i = 0; i < 20; i++) begin
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_quotient",  32'(quotient),  32'd66);
      chk("stall_remainder", 32'(remainder), 32'd2);
      chk("stall_in_ready",  32'(in_ready),  32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready",  32'(in_ready),  32'd1);
    chk("release_out_valid", 32'(out_valid), 32'd0);

    // Back-to-back throughput with out_ready high.
    send(8'd13, 8'd4, t0);
    send(8'd9,  8'd2, t1);
    chk("throughput", 32'(t1 - t0), 32'(W + 2));

    // Reset in the 4th CALC cycle abandons the operation.
    send(8'd99, 8'd9, t0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready",  32'(in_ready),  32'd1);
    chk("abort_pending",   32'(exp_q.size()), 32'd1);
    exp_q.delete();
    n_in--;
    op_with_latency(8'd10, 8'd3, 9);

    // Mixed traffic: in_valid held while busy, random gaps and stalls.
    rand_mode = 1'b1;
    for (int i = 0; i < 800; i++) begin
      a = W'($urandom);
      if ($urandom_range(0, 15) == 0)
        b = '0;
      else if ($urandom_range(0, 3) == 0)
        b = W'($urandom_range(1, 7));
      else
        b = W'($urandom_range(1, 255));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      dividend = a;
      divisor  = b;
      accepted = 1'b0;
      guard    = 0;
      while (!accepted && guard < 200) begin
        @(negedge clk);
        accepted = in_ready;
        @(posedge clk); #1;
        guard++;
      end
      in_valid = 1'b0;
      if (!accepted) chk("random_accept_timeout", 32'd0, 32'd1);
    end
    rand_mode = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    chk("ops_in_vs_out", 32'(n_out), 32'(n_in));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
